// File: rtl/fixed_p_std_sdiv_pipe.sv
// fixed_p_std_sdiv_pipe: iterative signed Q-format divider (clk, active-low sync reset, go, left, right -> out, done, overflow, div_by_zero)
module fixed_p_std_sdiv_pipe #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam int N = WIDTH + FRACT_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] LIM = N'(1) << (WIDTH - 1);
  localparam logic [N-1:0] MAXP = LIM - N'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0] r_rem;
  logic r_sign;
  logic [WIDTH-1:0] w_la, w_ra, w_qt, w_res;
  logic [WIDTH+1:0] w_sh;
  logic [WIDTH:0] w_rem;
  logic [N-1:0] w_q;
  logic w_ge, w_povf, w_novf;
  if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_chk
    $error("WIDTH must equal INT_WIDTH + FRACT_WIDTH");
  end
  assign w_la = left[WIDTH-1] ? -left : left;
  assign w_ra = right[WIDTH-1] ? -right : right;
  assign w_sh = {r_rem, r_dvd[N-1]};
  assign w_ge = w_sh >= {2'b00, r_dvs};
  assign w_rem = w_ge ? w_sh[WIDTH:0] - {1'b0, r_dvs} : w_sh[WIDTH:0];
  assign w_q = {r_dvd[N-2:0], w_ge};
  assign w_qt = w_q[WIDTH-1:0];
  assign w_res = r_sign ? -w_qt : w_qt;
  assign w_povf = !r_sign && w_q > MAXP;
  assign w_novf = r_sign && w_q > LIM;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_sign      <= 1'b0;
      out         <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (go) begin
          r_sign <= left[WIDTH-1] ^ right[WIDTH-1];
          r_dvd  <= {w_la, {FRACT_WIDTH{1'b0}}};
          r_dvs  <= w_ra;
          r_rem  <= '0;
          r_cnt  <= '0;
          if (right == '0) begin
            r_state     <= DONE;
            out         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem;
          r_dvd <= w_q;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state     <= DONE;
            done        <= 1'b1;
            out         <= w_povf ? {1'b0, {(WIDTH-1){1'b1}}} : w_novf ? {1'b1, {(WIDTH-1){1'b0}}} : w_res;
            overflow    <= w_povf || w_novf;
            div_by_zero <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_p_std_sdiv_pipe.sv
// tb_fixed_p_std_sdiv_pipe: randomized and directed checks of the divider against a behavioural model
module tb_fixed_p_std_sdiv_pipe;
  localparam int N = 12;
  logic clk = 1'b0;
  logic reset, go;
  logic [7:0] left, right, out;
  logic done, overflow, div_by_zero;
  int errs = 0;
  int checks = 0;
  int m_cnt = 0;
  bit m_done = 1'b0;
  logic [7:0] m_out = '0;
  bit m_ovf = 1'b0;
  bit m_dbz = 1'b0;
  logic [9:0] m_pend = '0;
  fixed_p_std_sdiv_pipe #(.WIDTH(8), .INT_WIDTH(4), .FRACT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out(out), .done(done), .overflow(overflow), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [9:0] ref_div(input logic [7:0] l, input logic [7:0] r);
    int a, b, q;
    bit s;
    if (r == 8'h00) return {8'h00, 2'b01};
    s = l[7] ^ r[7];
    a = $signed(l);
    b = $signed(r);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    q = (a * 16) / b;
    if (!s && q > 127) return {8'h7F, 2'b10};
    if (s && q > 128) return {8'h80, 2'b10};
    q = s ? -q : q;
    return {q[7:0], 2'b00};
  endfunction
  always @(posedge clk) begin
    if (!reset) begin
      m_cnt = 0; m_done = 1'b0; m_out = '0; m_ovf = 1'b0; m_dbz = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        {m_out, m_ovf, m_dbz} = m_pend;
        m_done = 1'b1;
      end
    end else if (go) begin
      m_pend = ref_div(left, right);
      if (right == 8'h00) begin
        {m_out, m_ovf, m_dbz} = m_pend;
        m_done = 1'b1;
      end else begin
        m_cnt = N;
      end
    end
    #1;
    chk("mdl_out", out, m_out);
    chk("mdl_done", done, m_done);
    chk("mdl_ovf", overflow, m_ovf);
    chk("mdl_dbz", div_by_zero, m_dbz);
  end
  task automatic run(input logic [7:0] l, input logic [7:0] r, input logic [7:0] eo, input bit eov, input bit edz, input int elat);
    int lat;
    @(negedge clk);
    left = l; right = r; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("lat %h/%h", l, r), lat, elat);
    chk($sformatf("out %h/%h", l, r), out, eo);
    chk($sformatf("ovf %h/%h", l, r), overflow, eov);
    chk($sformatf("dbz %h/%h", l, r), div_by_zero, edz);
    @(negedge clk);
  endtask
  initial begin
    int dc[$];
    int nd;
    reset = 1'b0; go = 1'b0; left = '0; right = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    run(8'h18, 8'h08, 8'h30, 0, 0, 13);
    run(8'h10, 8'h30, 8'h05, 0, 0, 13);
    run(8'hF0, 8'h30, 8'hFB, 0, 0, 13);
    run(8'hD0, 8'h20, 8'hE8, 0, 0, 13);
    run(8'h70, 8'h01, 8'h7F, 1, 0, 13);
    run(8'h80, 8'hF0, 8'h7F, 1, 0, 13);
    run(8'h80, 8'h10, 8'h80, 0, 0, 13);
    run(8'h10, 8'h00, 8'h00, 0, 1, 1);
    run(8'h18, 8'h08, 8'h30, 0, 0, 13);
    @(negedge clk);
    left = 8'h18; right = 8'h08; go = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      go = (c == 3 || c == 12 || c == 14);
      left = (c == 14) ? 8'h10 : 8'h70;
      right = (c == 14) ? 8'h30 : 8'h01;
      if (done) begin
        dc.push_back(c);
        if (c == 13) chk("ign_out1", out, 8'h30);
        if (c == 27) chk("ign_out2", out, 8'h05);
      end
    end
    go = 1'b0;
    chk("ign_ndone", dc.size(), 2);
    chk("ign_done1", dc.size() > 0 ? dc[0] : -1, 13);
    chk("ign_done2", dc.size() > 1 ? dc[1] : -1, 27);
    run(8'h70, 8'h01, 8'h7F, 1, 0, 13);
    run(8'h10, 8'h00, 8'h00, 0, 1, 1);
    left = 8'h18; right = 8'h08; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out", out, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_dbz", div_by_zero, 0);
    reset = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    run(8'h18, 8'h08, 8'h30, 0, 0, 13);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      go = $urandom_range(0, 2) != 0;
      left = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
      right = ($urandom_range(0, 15) == 0) ? 8'h00 : ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
      reset = $urandom_range(0, 299) != 0;
    end
    reset = 1'b1; go = 1'b0;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
